// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detected request flags, enable mask, priority select, irq held until ack.
// Optional round-robin priority when INT_CTRL_ROTATE_PRIO_EN is defined; fixed priority otherwise.
module int_ctrl #(
    parameter int unsigned NUM_SRC    = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] hw_req,
    input  logic               flag_wr,
    input  logic               enable_wr,
    input  logic [NUM_SRC-1:0] wr_data,
    output logic [NUM_SRC-1:0] flag,
    output logic [NUM_SRC-1:0] enable,
    output logic               irq,
    output logic [2:0]         irq_id,
    output logic [15:0]        irq_vec,
    input  logic               irq_ack
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    logic [NUM_SRC-1:0]   flag_q, flag_d;
    logic [NUM_SRC-1:0]   enable_q, enable_d;
    logic [NUM_SRC-1:0]   prev_q, prev_d;
    logic [0:0]           state_q, state_d;
    logic                 irq_q, irq_d;
    logic [2:0]           irq_id_q, irq_id_d;
    logic [15:0]          irq_vec_q, irq_vec_d;

    logic [NUM_SRC-1:0]   rise;
    logic [NUM_SRC-1:0]   active;
    logic [NUM_SRC-1:0]   ack_clr;
    logic [NUM_SRC-1:0]   id_onehot;
    logic [2*NUM_SRC-1:0] rot;
    logic                 found;
    logic [2:0]           win_id;
    logic [15:0]          win_vec;
    logic                 ack_fire;
    logic [2:0]           rr_cur;

`ifdef INT_CTRL_ROTATE_PRIO_EN
    logic [2:0] rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        if (ack_fire) begin
            rr_d = 3'((32'(irq_id_q) + 32'd1) % NUM_SRC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign rr_cur = rr_q;
`else
    assign rr_cur = '0;
`endif

    assign rise     = hw_req & ~prev_q;
    assign active   = flag_q & enable_q;
    assign ack_fire = (state_q == PENDING) && irq_ack;

    // Rotating a doubled copy makes index 0 of rot correspond to rr_cur.
    always_comb begin
        rot     = {active, active} >> rr_cur;
        found   = 1'b0;
        win_id  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!found && rot[i]) begin
                found  = 1'b1;
                win_id = 3'((32'(rr_cur) + i) % NUM_SRC);
            end
        end
        win_vec = VEC_BASE + 16'(32'(win_id) * VEC_STRIDE);
    end

    always_comb begin
        id_onehot    = '0;
        id_onehot[0] = 1'b1;
        id_onehot    = id_onehot << irq_id_q;
    end

    always_comb begin
        state_d   = state_q;
        irq_d     = irq_q;
        irq_id_d  = irq_id_q;
        irq_vec_d = irq_vec_q;
        ack_clr   = '0;
        case (state_q)
            IDLE: begin
                if (|active) begin
                    irq_id_d  = win_id;
                    irq_vec_d = win_vec;
                    irq_d     = 1'b1;
                    state_d   = PENDING;
                end
            end
            PENDING: begin
                if (irq_ack) begin
                    ack_clr = id_onehot;
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end else if ((active & id_onehot) == '0) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A new rise is ORed in last so it survives a same-cycle write or ack clear.
    always_comb begin
        prev_d   = hw_req;
        flag_d   = ((flag_wr ? wr_data : flag_q) & ~ack_clr) | rise;
        enable_d = enable_wr ? wr_data : enable_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q    <= '0;
            enable_q  <= '0;
            prev_q    <= '0;
            state_q   <= IDLE;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
            irq_vec_q <= '0;
        end else begin
            flag_q    <= flag_d;
            enable_q  <= enable_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
            irq_vec_q <= irq_vec_d;
        end
    end

    assign flag    = flag_q;
    assign enable  = enable_q;
    assign irq     = irq_q;
    assign irq_id  = irq_id_q;
    assign irq_vec = irq_vec_q;

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Parametrised interrupt controller; successor to the ad-hoc pending-register logic at system level.
- Registers flag (IF) and enable (IE) for NUM_SRC sources and edge-detects hardware requests.
- Selects the highest-priority pending-and-enabled source, latches its id and vector, and holds irq until the CPU acknowledges.
- Sits between peripherals (timer, LCD, serial, joypad), the MMU register bus and the CPU.

Parameters:
- NUM_SRC, 5, number of interrupt sources (1..8); bit 0 is highest fixed priority.
- VEC_BASE, 16'h0040, vector address of source 0.
- VEC_STRIDE, 8, vector spacing in bytes; vector = VEC_BASE + id*VEC_STRIDE, truncated to 16 bits.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hw_req  in  NUM_SRC  peripheral request levels; rising edges set flag bits.
- flag_wr  in  1  MMU write strobe for the flag register.
- enable_wr  in  1  MMU write strobe for the enable register.
- wr_data  in  NUM_SRC  write data for flag_wr/enable_wr.
- flag  out  NUM_SRC  current flag register.
- enable  out  NUM_SRC  current enable register.
- irq  out  1  interrupt request to CPU (registered).
- irq_id  out  3  latched source index; valid while irq=1.
- irq_vec  out  16  latched vector address; valid while irq=1.
- irq_ack  in  1  single-cycle CPU acknowledge.

Behaviour:
- Reset (async, immediate): flag=0, enable=0, edge-detect history=0, state=IDLE, irq=0, irq_id=0, irq_vec=0. The rotate pointer (optional feature) resets to 0.
- Edge detect:
  - rise[i] = hw_req[i] & ~prev[i]; prev <= hw_req every edge.
  - A level held high through reset release counts as one rise on the first edge.
- Flag next state: flag <= ((flag_wr ? wr_data : flag) & ~ack_clr) | rise.
  - rise always wins over a bus write or ack clear in the same cycle; no event is lost.
- Enable: enable <= wr_data on enable_wr; otherwise it holds.
- active = flag & enable, taken from registered values.
- Priority: fixed order selects the lowest set index of active.
- State IDLE:
  - If active != 0: latch irq_id=winner and irq_vec=vector(winner), set irq=1, go to PENDING.
  - irq_ack in IDLE is ignored.
- State PENDING:
  - irq_id and irq_vec are stable.
  - A higher-priority arrival does not preempt; it is serviced after this ack.
  - irq_ack=1: ack_clr = one-hot(irq_id), irq=0 the next cycle, go to IDLE.
  - Else if active[irq_id]=0 (withdrawn by a bus write to flag or enable): irq=0, go to IDLE, no clear.
- After ack, IDLE re-evaluates on the following edge, giving a minimum 1 idle cycle between requests.
- Latency: hw_req rises before edge t → flag bit set at t → irq=1 at t+1.
- Bits of wr_data above NUM_SRC do not exist; irq_id always < NUM_SRC.

Optional Feature:
- Macro: INT_CTRL_ROTATE_PRIO_EN.
- Defined:
  - Round-robin priority; the search starts at index rr_ptr and wraps modulo NUM_SRC.
  - On ack, rr_ptr <= (irq_id+1) mod NUM_SRC.
  - rr_ptr resets to 0, so the first selection after reset equals fixed priority.
- Undefined: fixed priority (index 0 highest); no rr_ptr state.

Test Plan:
- Reset then enable=5'b00100; pulse hw_req[2] → flag=5'b00100, irq=1 two edges later, irq_id=2, irq_vec=16'h0050; irq_ack → irq=0, flag=0 next cycle.
- enable=5'b11111, hw_req[4] and hw_req[1] rise in the same cycle → irq_id=1, irq_vec=16'h0048. After ack: idle 1 cycle, then irq_id=4, irq_vec=16'h0060.
- Same-cycle irq_ack for id 3 and new rise on hw_req[3] → flag[3] stays 1, irq re-asserts with irq_id=3 after one idle cycle.
- While PENDING on id 0, write enable=0 → irq drops the next cycle, flag[0] stays 1. Re-write enable=1 → irq returns with irq_id=0.
- hw_req[0] held high continuously → exactly one flag set. Assert rst mid-PENDING → irq=0, flag=0 immediately. After release, the held level sets flag[0] once.
- INT_CTRL_ROTATE_PRIO_EN, enable=5'b11111, sources 0 and 1 re-pulsed after every ack → grants alternate 0,1,0,1. Undefined: grants always 0.
